// File: rtl/i2c_ctrl_pkg.sv
// Shared encodings for the I2C controller top layer: mode FSM states and the
// default local address.
package i2c_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SLAVE  = 2'b01;
    localparam logic [1:0] ST_MASTER = 2'b10;

    localparam logic [6:0] DEF_RESET_ADDR = 7'h49;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and synchronous flush.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module i2c_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/i2c_controller_fifo.sv
// I2C controller top layer: host FIFOs, bus start/stop monitor and mode FSM over the engines.
// Optional build macro I2C_ARB_RETRY_EN enables automatic master retries after arbitration loss.
module i2c_controller_fifo
    import i2c_ctrl_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                FIFO_DEPTH   = 4,
    parameter int                ADDR_W       = 7,
    parameter logic [ADDR_W-1:0] RESET_ADDR   = ADDR_W'(DEF_RESET_ADDR),
    parameter int                SYNC_STAGES  = 2,
    parameter int                BUS_FREE_CYC = 64,
    parameter int                MAX_RETRY    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          cmd_start,
    input  logic [ADDR_W-1:0]             set_local_addr,
    output logic [ADDR_W-1:0]             local_addr,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [DATA_W-1:0]             core_wr_data,
    output logic                          core_wr_rdy,
    input  logic                          core_wr_reg_empty,
    input  logic [DATA_W-1:0]             core_rd_data,
    input  logic                          core_rd_reg_full,
    output logic                          core_rd_clr,
    input  logic                          core_arbit_fail,
    input  logic                          core_trans_stop,
    output logic                          master_en,
    output logic                          slave_en,
    output logic                          is_master,
    input  logic                          scl_i,
    input  logic                          sda_i,
    output logic                          bus_busy,
    output logic                          start_pend,
    output logic                          arbit_lost
);

    localparam int FREE_W = $clog2(BUS_FREE_CYC + 1);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, sda_prev;
    logic                   start_det, stop_det, free_hit;
    logic [FREE_W-1:0]      free_cnt;
    logic [1:0]             state, state_nxt;
    logic                   idle, enter_master, arb_fail_evt, retry_ok;
    logic                   tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0]      tx_head;
    logic                   tx_take, rx_take, wr_inflight, rd_inflight;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;
    // Clear on the same edge that free_cnt lands on BUS_FREE_CYC.
    assign free_hit  = scl_s & sda_s & (free_cnt == FREE_W'(BUS_FREE_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            sda_prev <= 1'b1;
            free_cnt <= '0;
            bus_busy <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            sda_prev <= sda_s;
            if (!(scl_s && sda_s))
                free_cnt <= '0;
            else if (free_cnt != FREE_W'(BUS_FREE_CYC))
                free_cnt <= free_cnt + 1'b1;
            if (start_det)
                bus_busy <= 1'b1;
            else if (stop_det || free_hit)
                bus_busy <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_SLAVE;
                ST_SLAVE:  if ((cmd_start || start_pend) && !bus_busy) state_nxt = ST_MASTER;
                ST_MASTER: if (core_arbit_fail || core_trans_stop) state_nxt = ST_SLAVE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    assign idle         = (state == ST_IDLE);
    assign enter_master = (state == ST_SLAVE) && (state_nxt == ST_MASTER);
    assign arb_fail_evt = (state == ST_MASTER) && core_arbit_fail;
    assign master_en    = (state == ST_MASTER);
    assign slave_en     = (state == ST_SLAVE);
    assign is_master    = (state == ST_MASTER);

`ifdef I2C_ARB_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] retry_cnt;

    assign retry_ok = arb_fail_evt && (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk) begin
        if (rst || idle)
            retry_cnt <= '0;
        else if (retry_ok)
            retry_cnt <= retry_cnt + 1'b1;
        else if (!arb_fail_evt && (core_trans_stop || cmd_start))
            retry_cnt <= '0;
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_pend <= 1'b0;
            arbit_lost <= 1'b0;
            local_addr <= RESET_ADDR;
        end else begin
            state <= state_nxt;
            if (idle) begin
                start_pend <= 1'b0;
                arbit_lost <= 1'b0;
                local_addr <= set_local_addr;
            end else begin
                if (arb_fail_evt && !retry_ok)
                    arbit_lost <= 1'b1;
                else if (cmd_start)
                    arbit_lost <= 1'b0;
                if (retry_ok)
                    start_pend <= 1'b1;
                else if (enter_master || arb_fail_evt)
                    start_pend <= 1'b0;
                else if (cmd_start && bus_busy)
                    start_pend <= 1'b1;
            end
        end
    end

    // Engine handshakes are one-shot pulses; the in-flight flags wait for the
    // engine to acknowledge before another byte may move.
    assign tx_take = !idle && core_wr_reg_empty && !tx_empty && !wr_inflight;
    assign rx_take = !idle && core_rd_reg_full && !rx_full && !rd_inflight;

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            core_wr_rdy  <= 1'b0;
            core_wr_data <= '0;
            wr_inflight  <= 1'b0;
            core_rd_clr  <= 1'b0;
            rd_inflight  <= 1'b0;
        end else begin
            core_wr_rdy <= tx_take;
            core_rd_clr <= rx_take;
            if (tx_take) begin
                core_wr_data <= tx_head;
                wr_inflight  <= 1'b1;
            end else if (!core_wr_reg_empty) begin
                wr_inflight  <= 1'b0;
            end
            if (rx_take)
                rd_inflight <= 1'b1;
            else if (!core_rd_reg_full)
                rd_inflight <= 1'b0;
        end
    end

    assign tx_ready = !tx_full && !idle;
    assign rx_valid = !rx_empty;

    i2c_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (idle),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (tx_take),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    i2c_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (idle),
        .push      (rx_take),
        .push_data (core_rd_data),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

endmodule

// File: tb/tb_i2c_controller_fifo.sv
// Directed bench for i2c_controller_fifo; define I2C_ARB_RETRY_EN here as in the RTL
// to exercise the arbitration retry path.
module tb_i2c_controller_fifo;

    logic       clk = 1'b0;
    logic       rst, enable, cmd_start;
    logic [6:0] set_local_addr, local_addr;
    logic [7:0] tx_data, rx_data, core_wr_data, core_rd_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic [2:0] tx_level, rx_level;
    logic       core_wr_rdy, core_wr_reg_empty, core_rd_reg_full, core_rd_clr;
    logic       core_arbit_fail, core_trans_stop;
    logic       master_en, slave_en, is_master;
    logic       scl_i, sda_i, bus_busy, start_pend, arbit_lost;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    i2c_controller_fifo dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd_start(cmd_start),
        .set_local_addr(set_local_addr), .local_addr(local_addr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .core_wr_data(core_wr_data), .core_wr_rdy(core_wr_rdy),
        .core_wr_reg_empty(core_wr_reg_empty), .core_rd_data(core_rd_data),
        .core_rd_reg_full(core_rd_reg_full), .core_rd_clr(core_rd_clr),
        .core_arbit_fail(core_arbit_fail), .core_trans_stop(core_trans_stop),
        .master_en(master_en), .slave_en(slave_en), .is_master(is_master),
        .scl_i(scl_i), .sda_i(sda_i), .bus_busy(bus_busy),
        .start_pend(start_pend), .arbit_lost(arbit_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cmd_start = 1'b0; set_local_addr = 7'h10;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        core_wr_reg_empty = 1'b0; core_rd_data = '0; core_rd_reg_full = 1'b0;
        core_arbit_fail = 1'b0; core_trans_stop = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
        repeat (3) tick();
        vectors++; if (local_addr !== 7'h49) begin miscompares++; $display("[TB] FAIL reset_addr: got %0h expected 49", local_addr); end
        vectors++; if ({master_en, slave_en, is_master, bus_busy, start_pend, arbit_lost, core_wr_rdy, core_rd_clr, tx_ready, rx_valid} !== 10'b0)
            begin miscompares++; $display("[TB] FAIL reset_outputs: got %b expected all zero", {master_en, slave_en, is_master, bus_busy, start_pend, arbit_lost, core_wr_rdy, core_rd_clr, tx_ready, rx_valid}); end
        vectors++; if ({tx_level, rx_level} !== 6'b0) begin miscompares++; $display("[TB] FAIL reset_levels: got %0d/%0d expected 0/0", tx_level, rx_level); end
        rst = 1'b0;
        tick();
        vectors++; if (local_addr !== 7'h10) begin miscompares++; $display("[TB] FAIL idle_addr_load: got %0h expected 10", local_addr); end
        enable = 1'b1;
        tick();
        vectors++; if ({master_en, slave_en, tx_ready} !== 3'b011) begin miscompares++; $display("[TB] FAIL enter_slave: got %b expected 011", {master_en, slave_en, tx_ready}); end
    endtask

    task automatic test_tx_stream();
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_data = 8'h3C;
        tick();
        tx_valid = 1'b0;
        vectors++; if (tx_level !== 3'd2) begin miscompares++; $display("[TB] FAIL tx_level_two: got %0d expected 2", tx_level); end
        vectors++; if (core_wr_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_hold_busy_reg: got %0b expected 0", core_wr_rdy); end
        core_wr_reg_empty = 1'b1;
        tick();
        vectors++; if ({core_wr_rdy, core_wr_data} !== {1'b1, 8'hA5}) begin miscompares++; $display("[TB] FAIL tx_first_byte: got rdy=%0b data=%0h expected rdy=1 data=a5", core_wr_rdy, core_wr_data); end
        vectors++; if (tx_level !== 3'd1) begin miscompares++; $display("[TB] FAIL tx_level_one: got %0d expected 1", tx_level); end
        tick();
        vectors++; if (core_wr_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_single_pulse: got %0b expected 0", core_wr_rdy); end
        tick();
        vectors++; if (core_wr_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_wait_inflight: got %0b expected 0", core_wr_rdy); end
        core_wr_reg_empty = 1'b0;
        tick();
        vectors++; if (core_wr_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_reg_busy: got %0b expected 0", core_wr_rdy); end
        core_wr_reg_empty = 1'b1;
        tick();
        vectors++; if ({core_wr_rdy, core_wr_data, tx_level} !== {1'b1, 8'h3C, 3'd0}) begin miscompares++; $display("[TB] FAIL tx_second_byte: got rdy=%0b data=%0h lvl=%0d expected rdy=1 data=3c lvl=0", core_wr_rdy, core_wr_data, tx_level); end
        tick();
        vectors++; if (core_wr_rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_second_pulse_len: got %0b expected 0", core_wr_rdy); end
    endtask

    task automatic test_rx_backpressure();
        logic [7:0] bytes [5];
        logic       seen;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            core_rd_data = bytes[i]; core_rd_reg_full = 1'b1;
            seen = 1'b0;
            for (int t = 0; t < 8 && !seen; t++) begin
                tick();
                seen = core_rd_clr;
            end
            vectors++; if (seen !== 1'b1 || rx_level !== 3'(i + 1)) begin miscompares++; $display("[TB] FAIL rx_accept_%0d: got clr=%0b lvl=%0d expected clr=1 lvl=%0d", i, seen, rx_level, i + 1); end
            core_rd_reg_full = 1'b0;
            tick();
        end
        core_rd_data = bytes[4]; core_rd_reg_full = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            seen = seen | core_rd_clr;
        end
        vectors++; if ({seen, rx_level} !== {1'b0, 3'd4}) begin miscompares++; $display("[TB] FAIL rx_full_withhold: got clr=%0b lvl=%0d expected clr=0 lvl=4", seen, rx_level); end
        vectors++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin miscompares++; $display("[TB] FAIL rx_head: got v=%0b d=%0h expected v=1 d=11", rx_valid, rx_data); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        vectors++; if ({core_rd_clr, rx_level} !== {1'b0, 3'd3}) begin miscompares++; $display("[TB] FAIL rx_after_pop: got clr=%0b lvl=%0d expected clr=0 lvl=3", core_rd_clr, rx_level); end
        tick();
        vectors++; if ({core_rd_clr, rx_level} !== {1'b1, 3'd4}) begin miscompares++; $display("[TB] FAIL rx_fifth_accept: got clr=%0b lvl=%0d expected clr=1 lvl=4", core_rd_clr, rx_level); end
        core_rd_reg_full = 1'b0;
        tick();
        rx_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            vectors++; if (rx_data !== bytes[j]) begin miscompares++; $display("[TB] FAIL rx_order_%0d: got %0h expected %0h", j, rx_data, bytes[j]); end
            tick();
        end
        rx_ready = 1'b0;
        vectors++; if ({rx_valid, rx_level} !== {1'b0, 3'd0}) begin miscompares++; $display("[TB] FAIL rx_drained: got v=%0b lvl=%0d expected v=0 lvl=0", rx_valid, rx_level); end
    endtask

    task automatic test_bus_free();
        sda_i = 1'b0;
        repeat (4) tick();
        vectors++; if (bus_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_on_start: got %0b expected 1", bus_busy); end
        scl_i = 1'b0;
        repeat (4) tick();
        sda_i = 1'b1;
        repeat (4) tick();
        vectors++; if (bus_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_no_stop: got %0b expected 1", bus_busy); end
        scl_i = 1'b1;
        repeat (65) tick();
        vectors++; if (bus_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_before_timeout: got %0b expected 1", bus_busy); end
        tick();
        vectors++; if (bus_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_timeout: got %0b expected 0", bus_busy); end
    endtask

    task automatic test_deferred_start();
        sda_i = 1'b0;
        repeat (4) tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        vectors++; if ({start_pend, slave_en, is_master} !== 3'b110) begin miscompares++; $display("[TB] FAIL pend_set: got %b expected 110", {start_pend, slave_en, is_master}); end
        repeat (3) tick();
        vectors++; if ({start_pend, is_master} !== 2'b10) begin miscompares++; $display("[TB] FAIL pend_wait: got %b expected 10", {start_pend, is_master}); end
        sda_i = 1'b1;
        tick();
        tick();
        vectors++; if (bus_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_sync_delay: got %0b expected 1", bus_busy); end
        tick();
        vectors++; if ({bus_busy, is_master} !== 2'b00) begin miscompares++; $display("[TB] FAIL stop_clears_busy: got %b expected 00", {bus_busy, is_master}); end
        tick();
        vectors++; if ({is_master, master_en, slave_en, start_pend} !== 4'b1100) begin miscompares++; $display("[TB] FAIL deferred_master: got %b expected 1100", {is_master, master_en, slave_en, start_pend}); end
    endtask

    task automatic test_arbitration();
`ifdef I2C_ARB_RETRY_EN
        for (int k = 0; k < 3; k++) begin
            core_arbit_fail = 1'b1;
            tick();
            core_arbit_fail = 1'b0;
            vectors++; if ({slave_en, start_pend, arbit_lost} !== 3'b110) begin miscompares++; $display("[TB] FAIL retry_%0d_slave: got %b expected 110", k, {slave_en, start_pend, arbit_lost}); end
            tick();
            vectors++; if (is_master !== 1'b1) begin miscompares++; $display("[TB] FAIL retry_%0d_master: got %0b expected 1", k, is_master); end
        end
`endif
        core_arbit_fail = 1'b1;
        tick();
        core_arbit_fail = 1'b0;
        vectors++; if ({slave_en, is_master, arbit_lost, start_pend} !== 4'b1010) begin miscompares++; $display("[TB] FAIL arb_lost: got %b expected 1010", {slave_en, is_master, arbit_lost, start_pend}); end
        repeat (3) tick();
        vectors++; if ({is_master, arbit_lost} !== 2'b01) begin miscompares++; $display("[TB] FAIL arb_sticky: got %b expected 01", {is_master, arbit_lost}); end
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        vectors++; if ({is_master, arbit_lost} !== 2'b10) begin miscompares++; $display("[TB] FAIL cmd_clears_lost: got %b expected 10", {is_master, arbit_lost}); end
        core_trans_stop = 1'b1;
        tick();
        core_trans_stop = 1'b0;
        vectors++; if ({slave_en, is_master} !== 2'b10) begin miscompares++; $display("[TB] FAIL trans_stop: got %b expected 10", {slave_en, is_master}); end
    endtask

    task automatic test_enable_low();
        core_wr_reg_empty = 1'b0;
        tick();
        tx_data = 8'h77; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        core_rd_data = 8'h99; core_rd_reg_full = 1'b1;
        tick();
        core_rd_reg_full = 1'b0;
        tick();
        vectors++; if ({tx_level, rx_level} !== {3'd1, 3'd1}) begin miscompares++; $display("[TB] FAIL levels_before_idle: got %0d/%0d expected 1/1", tx_level, rx_level); end
        set_local_addr = 7'h21;
        tick();
        vectors++; if (local_addr !== 7'h10) begin miscompares++; $display("[TB] FAIL addr_locked_active: got %0h expected 10", local_addr); end
        enable = 1'b0;
        tick();
        vectors++; if ({master_en, slave_en, tx_ready} !== 3'b000) begin miscompares++; $display("[TB] FAIL disable_idle: got %b expected 000", {master_en, slave_en, tx_ready}); end
        tick();
        vectors++; if ({tx_level, rx_level, rx_valid} !== 7'b0) begin miscompares++; $display("[TB] FAIL idle_flush: got %0d/%0d v=%0b expected 0/0 v=0", tx_level, rx_level, rx_valid); end
        vectors++; if (local_addr !== 7'h21) begin miscompares++; $display("[TB] FAIL idle_addr_21: got %0h expected 21", local_addr); end
    endtask

    initial begin
        test_reset();
        test_tx_stream();
        test_rx_backpressure();
        test_bus_free();
        test_deferred_start();
        test_arbitration();
        test_enable_low();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
